// File: rtl/trivium_pkg.sv
// Shared Trivium definitions: controller state encoding and key/IV/warm-up sizes.
package trivium_pkg;

  localparam int unsigned TRIV_KEY_W  = 80;
  localparam int unsigned TRIV_IV_W   = 80;
  localparam int unsigned TRIV_WARMUP = 1152;

  typedef enum logic [2:0] {
    LOAD_KEY,
    LOAD_IV,
    INIT,
    WARMUP,
    GEN,
    READY
  } triv_state_t;

endpackage

// File: rtl/trivium_seq.sv
// Trivium sequencer: loads key/IV byte-wise, runs the core warm-up, then packs
// core output bits into keystream bytes behind a one-byte-ahead valid/read handshake.
module trivium_seq
  import trivium_pkg::*;
#(
  parameter int unsigned KEY_BYTES    = 10,
  parameter int unsigned IV_BYTES     = 10,
  parameter int unsigned WARMUP_STEPS = TRIV_WARMUP
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic                  rekey,
  output logic                  busy,
  input  logic                  keystream_read,
  output logic [7:0]            keystream_byte,
  output logic                  keystream_valid,
  output logic                  core_init,
  output logic [TRIV_KEY_W-1:0] core_key,
  output logic [TRIV_IV_W-1:0]  core_iv,
  output logic                  core_step,
  input  logic                  core_ks_bit
);

  localparam int unsigned SW = $clog2(WARMUP_STEPS + 1);
  localparam logic [3:0]    KEY_LAST  = 4'(KEY_BYTES - 1);
  localparam logic [3:0]    IV_LAST   = 4'(IV_BYTES - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(WARMUP_STEPS - 1);

  triv_state_t   state;
  logic [3:0]    byte_cnt;
  logic [SW-1:0] step_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [7:0]    shreg_next;

  // Step k's bit lands in bit k; the 8th bit is folded in combinationally so
  // the completed byte can be registered in the same cycle as the last step.
  always_comb begin
    shreg_next          = shreg;
    shreg_next[bit_cnt] = core_ks_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= LOAD_KEY;
      byte_cnt        <= '0;
      step_cnt        <= '0;
      bit_cnt         <= '0;
      shreg           <= '0;
      core_key        <= '0;
      core_iv         <= '0;
      keystream_byte  <= '0;
      keystream_valid <= 1'b0;
      core_init       <= 1'b0;
      core_step       <= 1'b0;
      busy            <= 1'b0;
      cfg_ready       <= 1'b1;
    end else if (rekey) begin
      state           <= LOAD_KEY;
      byte_cnt        <= '0;
      step_cnt        <= '0;
      bit_cnt         <= '0;
      shreg           <= '0;
      keystream_valid <= 1'b0;
      core_init       <= 1'b0;
      core_step       <= 1'b0;
      busy            <= 1'b0;
      cfg_ready       <= 1'b1;
    end else begin
      core_init <= 1'b0;
      unique case (state)
        LOAD_KEY: begin
          if (cfg_valid) begin
            for (int unsigned i = 0; i < KEY_BYTES; i++)
              if (byte_cnt == 4'(i)) core_key[8*i +: 8] <= cfg_data;
            if (byte_cnt == KEY_LAST) begin
              byte_cnt <= '0;
              state    <= LOAD_IV;
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
            end
          end
        end
        LOAD_IV: begin
          if (cfg_valid) begin
            for (int unsigned i = 0; i < IV_BYTES; i++)
              if (byte_cnt == 4'(i)) core_iv[8*i +: 8] <= cfg_data;
            if (byte_cnt == IV_LAST) begin
              byte_cnt  <= '0;
              state     <= INIT;
              core_init <= 1'b1;
              busy      <= 1'b1;
              cfg_ready <= 1'b0;
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
            end
          end
        end
        INIT: begin
          state     <= WARMUP;
          core_step <= 1'b1;
        end
        WARMUP: begin
          if (step_cnt == STEP_LAST) begin
            step_cnt <= '0;
            state    <= GEN;
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        GEN: begin
          shreg <= shreg_next;
          if (bit_cnt == 3'd7) begin
            bit_cnt         <= '0;
            keystream_byte  <= shreg_next;
            keystream_valid <= 1'b1;
            core_step       <= 1'b0;
            busy            <= 1'b0;
            state           <= READY;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        READY: begin
          if (keystream_read && keystream_valid) begin
            keystream_valid <= 1'b0;
            core_step       <= 1'b1;
            busy            <= 1'b1;
            state           <= GEN;
          end
        end
        default: begin
          state     <= LOAD_KEY;
          cfg_ready <= 1'b1;
          core_step <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trivium_seq.sv
// Scoreboard bench for trivium_seq: a behavioural Trivium core drives core_ks_bit,
// expected loads and keystream bytes are queued by the stimulus and checked by a monitor.
module tb_trivium_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        rekey;
  logic        busy;
  logic        keystream_read;
  logic [7:0]  keystream_byte;
  logic        keystream_valid;
  logic        core_init;
  logic [79:0] core_key;
  logic [79:0] core_iv;
  logic        core_step;
  logic        core_ks_bit;

  always #5 clk = ~clk;

  trivium_seq #(.KEY_BYTES(10), .IV_BYTES(10), .WARMUP_STEPS(1152)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .rekey(rekey), .busy(busy),
    .keystream_read(keystream_read), .keystream_byte(keystream_byte),
    .keystream_valid(keystream_valid), .core_init(core_init), .core_key(core_key),
    .core_iv(core_iv), .core_step(core_step), .core_ks_bit(core_ks_bit)
  );

  // ---------------- Trivium reference functions ----------------
  function automatic logic [288:1] triv_load(input logic [79:0] k, input logic [79:0] v);
    logic [288:1] s;
    s = '0;
    for (int i = 1; i <= 80; i++) begin
      s[i]      = k[i-1];
      s[93 + i] = v[i-1];
    end
    s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
    return s;
  endfunction

  function automatic logic triv_z(input logic [288:1] s);
    return s[66] ^ s[93] ^ s[162] ^ s[177] ^ s[243] ^ s[288];
  endfunction

  function automatic logic [288:1] triv_next(input logic [288:1] s);
    logic [288:1] n;
    logic t1, t2, t3;
    t1 = s[66]  ^ s[93]  ^ (s[91]  & s[92])  ^ s[171];
    t2 = s[162] ^ s[177] ^ (s[175] & s[176]) ^ s[264];
    t3 = s[243] ^ s[288] ^ (s[286] & s[287]) ^ s[69];
    n = s;
    n[93:1]    = {s[92:1], t3};
    n[177:94]  = {s[176:94], t1};
    n[288:178] = {s[287:178], t2};
    return n;
  endfunction

  // Behavioural core attached to the sequencer's control outputs
  logic [288:1] core_st = '0;
  always @(posedge clk) begin
    if (core_init)      core_st <= triv_load(core_key, core_iv);
    else if (core_step) core_st <= triv_next(core_st);
  end
  assign core_ks_bit = triv_z(core_st);

  // Golden keystream generator advanced by the stimulus
  logic [288:1] gold;
  task automatic gold_load(input logic [79:0] k, input logic [79:0] v);
    gold = triv_load(k, v);
    repeat (1152) gold = triv_next(gold);
  endtask

  function automatic logic [7:0] next_byte();
    logic [7:0] b;
    for (int k = 0; k < 8; k++) begin
      b[k] = triv_z(gold);
      gold = triv_next(gold);
    end
    return b;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [79:0] k;
    logic [79:0] v;
  } ld_t;

  ld_t        load_q[$];
  logic [7:0] ks_q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic checki(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // ---------------- monitor ----------------
  int steps = 0, init_cyc = 0, rd_cyc = 0;
  bit first = 0, rd_pend = 0, prev_valid = 0;
  ld_t ld;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 0;
      rd_pend    = 0;
      first      = 0;
    end else begin
      if (core_step) steps++;
      if (core_init) begin
        if (load_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL init_unexpected: core_init pulse with no load queued (cycle %0d)", cyc);
        end else begin
          ld = load_q.pop_front();
          check("core_key", core_key, ld.k);
          check("core_iv", core_iv, ld.v);
        end
        init_cyc = cyc;
        steps    = 0;
        first    = 1;
      end
      if (keystream_valid && !prev_valid) begin
        if (ks_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL ks_unexpected: byte %h with none expected (cycle %0d)", keystream_byte, cyc);
        end else begin
          check("ks_byte", {72'h0, keystream_byte}, {72'h0, ks_q.pop_front()});
        end
        if (first) begin
          checki("warmup_latency", cyc - init_cyc, 1161);
          checki("warmup_steps", steps, 1160);
          first = 0;
        end else if (rd_pend) begin
          checki("read_latency", cyc - rd_cyc, 9);
        end
        rd_pend = 0;
      end
      if (keystream_read && keystream_valid && !rekey) begin
        rd_pend = 1;
        rd_cyc  = cyc;
      end
      if (rekey) begin
        rd_pend = 0;
        first   = 0;
      end
      prev_valid = keystream_valid;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    cfg_data  = b;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic load(input logic [79:0] k, input logic [79:0] v);
    ld_t e;
    e.k = k;
    e.v = v;
    load_q.push_back(e);
    gold_load(k, v);
    ks_q.push_back(next_byte());
    for (int i = 0; i < 10; i++) send_byte(k[8*i +: 8]);
    for (int i = 0; i < 10; i++) send_byte(v[8*i +: 8]);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!keystream_valid && n < 3000) begin
      tick();
      n++;
    end
    check("wait_valid", {79'h0, keystream_valid}, 80'h1);
  endtask

  task automatic pulse_read();
    keystream_read = 1'b1;
    ks_q.push_back(next_byte());
    tick();
    keystream_read = 1'b0;
  endtask

  localparam logic [79:0] K1 = 80'h09080706050403020100;
  localparam logic [79:0] V1 = 80'hA9A8A7A6A5A4A3A2A1A0;
  localparam logic [79:0] K2 = 80'h0123456789ABCDEF0011;
  localparam logic [79:0] V2 = 80'hFEDCBA98765432100F1E;

  initial begin
    rst_n = 1'b0; cfg_data = '0; cfg_valid = 1'b0; rekey = 1'b0; keystream_read = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: idle after reset
    check("rst_core_key", core_key, '0);
    check("rst_core_iv", core_iv, '0);
    check("rst_ks_byte", {72'h0, keystream_byte}, '0);
    check("rst_busy", {79'h0, busy}, '0);
    for (int i = 0; i < 100; i++) begin
      check("idle_ctrl", {77'h0, cfg_ready, keystream_valid, core_step}, 80'h4);
      tick();
    end

    // 2: key 00..09 / IV A0..A9, single init pulse, full warm-up
    load(K1, V1);
    check("init_pulse", {78'h0, core_init, core_step}, 80'h2);
    tick();
    check("init_end", {78'h0, core_init, core_step}, 80'h1);
    check("busy_warmup", {79'h0, busy}, 80'h1);
    wait_valid();

    // 3: key = IV = 0, 16 back-to-back reads
    rekey = 1'b1; tick(); rekey = 1'b0;
    ks_q.delete();
    load('0, '0);
    for (int i = 0; i < 16; i++) begin
      wait_valid();
      pulse_read();
    end

    // 4: cfg traffic in READY ignored; read with valid low not remembered
    wait_valid();
    cfg_data = 8'hFF; cfg_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("cfg_ready_ready", {79'h0, cfg_ready}, '0);
      tick();
    end
    cfg_valid = 1'b0;
    check("key_hold", core_key, '0);
    check("iv_hold", core_iv, '0);
    check("valid_hold", {79'h0, keystream_valid}, 80'h1);
    pulse_read();
    keystream_read = 1'b1;
    repeat (3) tick();
    keystream_read = 1'b0;
    wait_valid();
    repeat (12) tick();
    check("read_not_remembered", {78'h0, keystream_valid, busy}, 80'h2);

    // 5: rekey at warm-up step 500, then a full fresh warm-up
    rekey = 1'b1; tick(); rekey = 1'b0;
    ks_q.delete();
    load(K1, V1);
    for (int i = 0; i < 500; i++) begin
      if (i == 100) begin
        cfg_data = 8'h33; cfg_valid = 1'b1;
      end
      if (i == 101) check("cfg_ready_warmup", {79'h0, cfg_ready}, '0);
      tick();
      cfg_valid = 1'b0;
    end
    check("step_500", {79'h0, core_step}, 80'h1);
    rekey = 1'b1; cfg_data = 8'h5A; cfg_valid = 1'b1;
    tick();
    rekey = 1'b0; cfg_valid = 1'b0;
    ks_q.delete();
    check("rekey_ctrl", {76'h0, core_step, keystream_valid, cfg_ready, busy}, 80'h2);
    check("rekey_key_kept", core_key, K1);
    check("rekey_iv_kept", core_iv, V1);
    for (int i = 0; i < 20; i++) begin
      check("rekey_idle_step", {79'h0, core_step}, '0);
      tick();
    end
    load(K2, V2);
    wait_valid();

    // 6: rekey together with read in READY, then partial load discarded
    rekey = 1'b1; keystream_read = 1'b1;
    tick();
    rekey = 1'b0; keystream_read = 1'b0;
    ks_q.delete();
    check("rekey_read_ctrl", {76'h0, core_step, keystream_valid, cfg_ready, busy}, 80'h2);
    repeat (15) tick();
    check("rekey_read_idle", {78'h0, keystream_valid, core_step}, '0);
    for (int i = 0; i < 3; i++) send_byte(8'hEE);
    rekey = 1'b1; tick(); rekey = 1'b0;
    load(K1, V1);
    wait_valid();

    // asynchronous reset in the middle of warm-up
    rekey = 1'b1; tick(); rekey = 1'b0;
    ks_q.delete();
    load(K2, V2);
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", {77'h0, core_step, busy, cfg_ready}, 80'h1);
    check("async_rst_key", core_key, '0);
    ks_q.delete();
    tick();
    rst_n = 1'b1;

    checki("ks_q_drained", ks_q.size(), 0);
    checki("load_q_drained", load_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
